// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
//
// Drives every input combination {a,b,c} = 0..7 into a 3-input
// combinational unit under test. Each vector is held for SETTLE cycles,
// and the unit's response y is then captured into table_out. When the
// sweep is complete, the captured table is compared against a golden
// truth table that was latched when the sweep started.
//
// Parameters
//   SETTLE      cycles each vector is held before y is sampled (1..15)
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   start       request one sweep; accepted in IDLE or DONE, ignored in RUN
//   expected    golden table, bit i = required y for {a,b,c} = i
//   y           response of the unit under test
//   a, b, c     registered stimulus, {a,b,c} = vector index (a is MSB)
//   busy        high while a sweep is in progress
//   done        high from completion until the next accepted start or reset
//   pass        table_out == latched expected (valid while done)
//   table_out   captured responses, bit i = y sampled for vector i
//   mismatch    table_out ^ latched expected (valid while done)
//   vec_strobe  one-cycle pulse after each edge that captures a y sample
//   fsm_state   debug view of the FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is a level sampled on each rising edge. It is acted on
// only when busy is low, and nothing is returned to acknowledge it. The
// caller sees busy rise on the accepting edge and then waits for done.
module truth_table_sequencer #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] expected,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] table_out,
   output logic [7:0] mismatch,
   output logic       vec_strobe,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter runs from SETTLE-1 down to 0. A sample is taken on the edge
   // that sees it at 0, which gives exactly SETTLE cycles per vector.
   localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] table_q, table_d;
   logic [7:0] exp_q, exp_d;
   logic [7:0] mism_q, mism_d;
   logic       pass_q, pass_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [2:0] abc_q, abc_d;
   logic       strobe_q, strobe_d;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      table_d  = table_q;
      exp_d    = exp_q;
      mism_d   = mism_q;
      pass_d   = pass_q;
      busy_d   = busy_q;
      done_d   = done_q;
      abc_d    = abc_q;
      strobe_d = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               idx_d   = 3'd0;
               cnt_d   = SETTLE_RELOAD;
               table_d = 8'h00;
               exp_d   = expected;
               mism_d  = 8'h00;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               abc_d   = 3'd0;
            end
         end
         RUN: begin
            if (cnt_q == 4'd0) begin
               // y is still the response to the vector that is currently applied,
               // because the new vector only appears after this edge.
               strobe_d       = 1'b1;
               table_d[idx_q] = y;
               if (idx_q == 3'd7) begin
                  // The final result uses table_d, so it includes bit 7,
                  // which is captured on this same edge.
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  abc_d   = 3'd0;
                  pass_d  = (table_d == exp_q);
                  mism_d  = table_d ^ exp_q;
               end else begin
                  idx_d = idx_q + 3'd1;
                  abc_d = idx_q + 3'd1;
                  cnt_d = SETTLE_RELOAD;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= 3'd0;
         cnt_q    <= 4'd0;
         table_q  <= 8'h00;
         exp_q    <= 8'h00;
         mism_q   <= 8'h00;
         pass_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         abc_q    <= 3'd0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         table_q  <= table_d;
         exp_q    <= exp_d;
         mism_q   <= mism_d;
         pass_q   <= pass_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         abc_q    <= abc_d;
         strobe_q <= strobe_d;
      end
   end

   assign a          = abc_q[2];
   assign b          = abc_q[1];
   assign c          = abc_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign table_out  = table_q;
   assign mismatch   = mism_q;
   assign vec_strobe = strobe_q;
   assign fsm_state  = state_q;

endmodule
